// File: rtl/rr_packet_arbiter.sv
// Round-robin packet arbiter: locks a grant from head flit to tail flit.
// Optional macro ARB_FAST_REARB_EN re-arbitrates on the release edge instead of idling a cycle.
module rr_packet_arbiter #(
  parameter int IO_SIZE = 5,
  parameter int IO_w    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IO_SIZE-1:0] request,
  input  logic [IO_SIZE-1:0] tail,
  input  logic [IO_w-1:0]    token,
  input  logic               advance,
  output logic [IO_SIZE-1:0] grant,
  output logic               grant_valid,
  output logic [IO_w-1:0]    grant_id
);

  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;

  localparam logic [IO_SIZE-1:0] ONE = {{(IO_SIZE-1){1'b0}}, 1'b1};

  // Returns {found, index} of the first set bit at or after start, wrapping.
  function automatic logic [IO_w:0] scan(input logic [IO_SIZE-1:0] req, input int start);
    logic [IO_w:0] res;
    int            idx;
    res = '0;
    for (int i = 0; i < IO_SIZE; i++) begin
      idx = (start + i) % IO_SIZE;
      if (!res[IO_w] && req[idx]) res = {1'b1, IO_w'(idx)};
    end
    return res;
  endfunction

  logic [IO_w:0] idle_pick;
  logic          release_now;

  always_comb begin
    idle_pick = scan(request, (int'(token) >= IO_SIZE) ? 0 : int'(token));
  end

  assign release_now = grant_valid && advance && tail[grant_id];

`ifdef ARB_FAST_REARB_EN
  // The token stage lags a cycle, so the fast path restarts just past the current owner.
  logic [IO_w:0] fast_pick;
  always_comb begin
    fast_pick = scan(request & ~grant, int'(grant_id) + 1);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_pick[IO_w]) begin
            state       <= LOCKED;
            grant       <= ONE << idle_pick[IO_w-1:0];
            grant_valid <= 1'b1;
            grant_id    <= idle_pick[IO_w-1:0];
          end
        end
        LOCKED: begin
          if (release_now) begin
`ifdef ARB_FAST_REARB_EN
            if (fast_pick[IO_w]) begin
              grant    <= ONE << fast_pick[IO_w-1:0];
              grant_id <= fast_pick[IO_w-1:0];
            end else begin
              state       <= IDLE;
              grant       <= '0;
              grant_valid <= 1'b0;
              grant_id    <= '0;
            end
`else
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Self-checking bench for rr_packet_arbiter: vector table, corner sequences, random stream.
module tb_rr_packet_arbiter;
  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] request = '0;
  logic [4:0] tail = '0;
  logic [2:0] token = '0;
  logic       advance = 1'b0;
  logic [4:0] grant;
  logic       grant_valid;
  logic [2:0] grant_id;

  int tests = 0;
  int fails = 0;

  rr_packet_arbiter #(.IO_SIZE(N), .IO_w(3)) dut (
    .clk(clk), .rst_n(rst_n), .request(request), .tail(tail), .token(token),
    .advance(advance), .grant(grant), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] req;
    logic [4:0] tl;
    logic [2:0] tok;
    logic       adv;
    logic [4:0] eg;
    logic [2:0] eid;
    logic       ev;
  } vec_t;

  typedef struct {
    logic [4:0] eg;
    logic [2:0] eid;
    logic       ev;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare just after the edge.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    @(negedge clk);
    request = v.req; tail = v.tl; token = v.tok; advance = v.adv;
    sb.push_back('{eg: v.eg, eid: v.eid, ev: v.ev});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({name, "_grant"}, 32'(grant), 32'(e.eg));
    check({name, "_id"}, 32'(grant_id), 32'(e.eid));
    check({name, "_valid"}, 32'(grant_valid), 32'(e.ev));
    $display("[TB] %s req=%b tail=%b tok=%0d adv=%0d -> grant=%b id=%0d valid=%0d",
             name, v.req, v.tl, v.tok, v.adv, grant, grant_id, grant_valid);
  endtask

  function automatic int first_set(input logic [4:0] r, input int s);
    int k;
    for (int i = 0; i < N; i++) begin
      k = (s + i) % N;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{5'b10100, 5'b00000, 3'd3, 1'b0, 5'b10000, 3'd4, 1'b1}; // token 3 picks 4
    tbl[1]  = '{5'b00001, 5'b00000, 3'd0, 1'b1, 5'b10000, 3'd4, 1'b1}; // advance, no tail
    tbl[2]  = '{5'b00000, 5'b10000, 3'd0, 1'b0, 5'b10000, 3'd4, 1'b1}; // tail, no advance
    tbl[3]  = '{5'b00000, 5'b10000, 3'd0, 1'b1, 5'b00000, 3'd0, 1'b0}; // release
    tbl[4]  = '{5'b00110, 5'b00000, 3'd5, 1'b0, 5'b00010, 3'd1, 1'b1}; // token 5 -> 0
    tbl[5]  = '{5'b00010, 5'b00010, 3'd0, 1'b1, 5'b00000, 3'd0, 1'b0};
    tbl[6]  = '{5'b00000, 5'b11111, 3'd0, 1'b1, 5'b00000, 3'd0, 1'b0}; // advance in idle
    tbl[7]  = '{5'b01001, 5'b00000, 3'd4, 1'b0, 5'b00001, 3'd0, 1'b1}; // wrap 4 -> 0
    tbl[8]  = '{5'b00000, 5'b00000, 3'd0, 1'b1, 5'b00001, 3'd0, 1'b1}; // request dropped, held
    tbl[9]  = '{5'b00000, 5'b00001, 3'd0, 1'b1, 5'b00000, 3'd0, 1'b0};
    tbl[10] = '{5'b11111, 5'b00000, 3'd7, 1'b0, 5'b00001, 3'd0, 1'b1}; // token 7 -> 0
    tbl[11] = '{5'b11111, 5'b11110, 3'd3, 1'b1, 5'b00001, 3'd0, 1'b1}; // other tails ignored
    tbl[12] = '{5'b00001, 5'b00001, 3'd0, 1'b1, 5'b00000, 3'd0, 1'b0};
    tbl[13] = '{5'b00000, 5'b00000, 3'd0, 1'b0, 5'b00000, 3'd0, 1'b0}; // empty idle
    tbl[14] = '{5'b00100, 5'b00000, 3'd2, 1'b0, 5'b00100, 3'd2, 1'b1}; // lock id 2
  end

  initial begin
    logic [4:0] pend;
    logic [4:0] pre_g, pre_req;
    logic [2:0] pre_id, tok_r;
    logic       pre_v, rel, exp_v;
    int         exp_id, waitc[N];

    #3;
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_valid", 32'(grant_valid), 32'd0);
    check("reset_id", 32'(grant_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Locked on id 2: three advance-without-tail cycles, then release.
    for (int i = 0; i < 3; i++)
      apply('{5'b00100, 5'b11011, 3'd0, 1'b1, 5'b00100, 3'd2, 1'b1}, $sformatf("hold%0d", i));
    apply('{5'b00100, 5'b00100, 3'd0, 1'b1, 5'b00000, 3'd0, 1'b0}, "release2");

    // Release of id 4 with id 0 waiting.
    apply('{5'b10000, 5'b00000, 3'd4, 1'b0, 5'b10000, 3'd4, 1'b1}, "lock4");
`ifdef ARB_FAST_REARB_EN
    apply('{5'b10001, 5'b10000, 3'd4, 1'b1, 5'b00001, 3'd0, 1'b1}, "fast_rearb");
`else
    apply('{5'b10001, 5'b10000, 3'd4, 1'b1, 5'b00000, 3'd0, 1'b0}, "bubble");
    apply('{5'b00001, 5'b00000, 3'd4, 1'b0, 5'b00001, 3'd0, 1'b1}, "after_bubble");
`endif
    apply('{5'b00000, 5'b00001, 3'd0, 1'b1, 5'b00000, 3'd0, 1'b0}, "release0");

    // Asynchronous reset mid-packet.
    apply('{5'b00100, 5'b00000, 3'd0, 1'b0, 5'b00100, 3'd2, 1'b1}, "pre_reset_lock");
    @(negedge clk);
    request = '0; advance = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_grant", 32'(grant), 32'd0);
    check("async_valid", 32'(grant_valid), 32'd0);
    check("async_id", 32'(grant_id), 32'd0);
    $display("[TB] async reset mid-packet -> grant=%b valid=%0d", grant, grant_valid);
    @(negedge clk);
    rst_n = 1'b1;
    apply('{5'b01000, 5'b00000, 3'd0, 1'b0, 5'b01000, 3'd3, 1'b1}, "post_reset");
    apply('{5'b01000, 5'b01000, 3'd0, 1'b1, 5'b00000, 3'd0, 1'b0}, "post_release");

    // Random stream with a modelled token stage and fairness tracking.
    pend = '0; tok_r = '0;
    for (int j = 0; j < N; j++) waitc[j] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      for (int j = 0; j < N; j++) if (!pend[j] && $urandom_range(3) == 0) pend[j] = 1'b1;
      request = pend;
      tail = 5'($urandom);
      advance = 1'($urandom_range(1));
      token = tok_r;
      #1;
      pre_g = grant; pre_id = grant_id; pre_v = grant_valid; pre_req = request;
      rel = pre_v && advance && tail[pre_id];
      @(posedge clk);
      #1;
      check("onehot", 32'($countones(grant) <= 1), 32'd1);
      check("valid_or", 32'(grant_valid), 32'(|grant));
      if (pre_v && !rel) begin
        check("lock_hold", {24'd0, grant, grant_id}, {24'd0, pre_g, pre_id});
      end else begin
        exp_v = 1'b0; exp_id = 0;
        if (!pre_v && pre_req != 0) begin
          exp_v = 1'b1; exp_id = first_set(pre_req, (token >= 3'd5) ? 0 : int'(token));
        end
`ifdef ARB_FAST_REARB_EN
        if (rel && (pre_req & ~pre_g) != 0) begin
          exp_v = 1'b1; exp_id = first_set(pre_req & ~pre_g, int'(pre_id) + 1);
        end
`endif
        check("arb_valid", 32'(grant_valid), 32'(exp_v));
        check("arb_id", 32'(grant_id), 32'(exp_id));
        if (grant_valid) begin
          for (int j = 0; j < N; j++) begin
            if (j != int'(grant_id) && pre_req[j]) begin
              waitc[j]++;
              check($sformatf("fair%0d", j), 32'(waitc[j] <= N - 1), 32'd1);
            end
          end
          waitc[grant_id] = 0;
        end
      end
      if (grant_valid) check("grant_match", 32'(grant), 32'(5'b00001 << grant_id));
      else check("id_zero", 32'(grant_id), 32'd0);
      if (grant_valid) tok_r = 3'((int'(grant_id) + 1) % N);
      if (rel) pend[pre_id] = 1'b0;
    end
    $display("[TB] random stream of 10000 cycles complete");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_packet_arbiter.md
RR_PACKET_ARBITER -- requirements
Module: rr_packet_arbiter

Interface
REQ-001 SHALL have parameter IO_SIZE, default 5, giving the number of requesters.
REQ-002 SHALL have parameter IO_w, default 3, giving the width of the requester index; IO_w >= clog2(IO_SIZE).
REQ-003 SHALL have port clk  input  1  single clock; all state rises on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port request  input  IO_SIZE  per-requester flit-pending flags.
REQ-006 SHALL have port tail  input  IO_SIZE  per-requester flag: the current flit is a packet tail.
REQ-007 SHALL have port token  input  IO_w  round-robin start index from the downstream token-update stage.
REQ-008 SHALL have port advance  input  1  downstream accepted the granted flit this cycle.
REQ-009 SHALL have port grant  output  IO_SIZE  registered one-hot grant, fed straight to the token-update stage vector input.
REQ-010 SHALL have port grant_valid  output  1  registered; equals |grant.
REQ-011 SHALL have port grant_id  output  IO_w  registered binary index of the granted requester; 0 when no grant.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and LOCKED; grant is all-zero in IDLE.
REQ-013 In IDLE with |request=1 at edge t, SHALL select the first set request bit scanning from index token upward, wrapping IDLE_SIZE-1 -> 0, and present the one-hot grant at t+1 while entering LOCKED.
REQ-014 SHALL treat token >= IO_SIZE as 0.
REQ-015 In IDLE with request all-zero, SHALL stay in IDLE with grant zero.
REQ-016 In LOCKED, SHALL hold grant, grant_id and grant_valid constant, ignoring token and the other requests, until release.
REQ-017 Release SHALL occur when advance=1 and tail[grant_id]=1 in the same cycle; advance without the tail bit, or the tail bit without advance, SHALL NOT release.
REQ-018 Deassertion of request[grant_id] while LOCKED SHALL NOT release the lock; packets are never split.
REQ-019 On release at edge t (macro absent), SHALL return to IDLE with grant zero at t+1; the next grant appears no earlier than t+2.
REQ-020 advance while in IDLE SHALL be ignored.
REQ-021 grant SHALL never have more than one bit set in any cycle.

Reset
REQ-022 rst_n=0 SHALL asynchronously force FSM=IDLE, grant=0, grant_valid=0 and grant_id=0, independent of clk.
REQ-023 Reset asserted mid-packet SHALL discard the lock; after deassertion, arbitration restarts from IDLE using the current token.

Configuration
REQ-024 Macro ARB_FAST_REARB_EN, when defined, SHALL enable same-cycle re-arbitration on release: if any request bit other than grant_id is set at release edge t, the new grant appears at t+1 (FSM stays LOCKED). The scan starts at (grant_id+1) mod IO_SIZE rather than at token, because the token stage lags by one cycle.
REQ-025 With ARB_FAST_REARB_EN defined and no other request pending at release, SHALL behave as REQ-019.
REQ-026 Without ARB_FAST_REARB_EN, SHALL behave exactly as REQ-019, and no re-arbitration logic SHALL be synthesized.

Verification (IO_SIZE=5, IO_w=3)
REQ-027 SHALL test: reset, then request=5'b10100, token=3 -> grant=5'b10000, grant_id=4 one cycle later.
REQ-028 SHALL test: token=5, request=5'b00110 -> token treated as 0, grant=5'b00010, grant_id=1.
REQ-029 SHALL test: locked on id 2 with advance=1, tail=0 for 3 cycles, then advance=1, tail[2]=1 -> grant held during the 3 cycles, zero on the cycle after release (macro off).
REQ-030 SHALL test: macro on, locked on id 4, request=5'b10001, release -> grant=5'b00001 on the next cycle with no zero bubble.
REQ-031 SHALL test: rst_n pulled low mid-packet between clock edges -> grant=0 immediately, without waiting for an edge; after rst_n rises, request=5'b01000 -> grant=5'b01000 one cycle later.
REQ-032 SHALL test: a random stream of requests, tails and advance over 10k cycles -> grant is always one-hot or zero, and no requester waits more than IO_SIZE-1 packets while continuously requesting.
